// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: coin credit, per-item stock, one-cycle vend pulse.
// Optional refund path enabled by the VENDING_CHANGE_EN macro.
module vending_machine_multi #(
  parameter int N_ITEMS    = 4,
  parameter int PRICE      = 5,
  parameter int CREDIT_W   = 4,
  parameter int MAX_CREDIT = 15,
  parameter int STOCK_W    = 3,
  parameter int INIT_STOCK = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       coin_valid,
  input  logic [CREDIT_W-1:0]        coin_value,
  input  logic                       sel_valid,
  input  logic [$clog2(N_ITEMS)-1:0] sel_item,
  input  logic                       cancel,
  input  logic                       restock,
  input  logic [$clog2(N_ITEMS)-1:0] restock_item,
  output logic                       item_out,
  output logic [$clog2(N_ITEMS)-1:0] item_id,
  output logic                       change_out,
  output logic [CREDIT_W-1:0]        credit,
  output logic [N_ITEMS-1:0]         sold_out,
  output logic                       err,
  output logic                       busy
);

  localparam int SW = $clog2(N_ITEMS);
  localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_C      = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [STOCK_W-1:0]  STOCK_MAX  = {STOCK_W{1'b1}};
  localparam logic [STOCK_W-1:0]  STOCK_INIT = STOCK_W'(INIT_STOCK);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2
`ifdef VENDING_CHANGE_EN
    ,S_CHANGE = 2'd3
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [SW-1:0]        sel_q, sel_d;
  logic                 err_q, err_d;
  logic [STOCK_W-1:0]   stock_q [N_ITEMS];
  logic [STOCK_W-1:0]   stock_d [N_ITEMS];

  logic [CREDIT_W:0]    coin_sum;
  logic                 coin_ok;
  logic                 sel_hit;
  logic [STOCK_W-1:0]   sel_stock;
  logic                 sel_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      sel_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_INIT;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= stock_d[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    sel_d     = sel_q;
    err_d     = 1'b0;
    sel_hit   = 1'b0;
    sel_stock = '0;
    coin_sum  = {1'b0, credit_q} + {1'b0, coin_value};
    coin_ok   = (coin_value != '0) && (coin_sum <= MAX_C);
    // Out-of-range indices never match, so they leave sel_hit low.
    for (int i = 0; i < N_ITEMS; i++) begin
      if (sel_item == SW'(i)) begin
        sel_hit   = 1'b1;
        sel_stock = stock_q[i];
      end else begin
        sel_hit   = sel_hit;
      end
    end
    sel_ok = sel_hit && (sel_stock != '0) && (credit_q >= PRICE_C);

    case (state_q)
      S_IDLE, S_CREDIT: begin
        if (cancel) begin
          err_d = coin_valid;
          if (state_q == S_CREDIT) begin
`ifdef VENDING_CHANGE_EN
            state_d = S_CHANGE;
`else
            state_d  = S_IDLE;
            credit_d = '0;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end else if (sel_valid) begin
          err_d = coin_valid || !sel_ok;
          if (sel_ok) begin
            state_d = S_VEND;
            sel_d   = sel_item;
          end else begin
            state_d = state_q;
          end
        end else if (coin_valid) begin
          if (coin_ok) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = S_CREDIT;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_VEND: begin
        err_d    = coin_valid;
        credit_d = credit_q - PRICE_C;
        if (credit_q == PRICE_C) begin
          state_d = S_IDLE;
        end else begin
`ifdef VENDING_CHANGE_EN
          state_d = S_CHANGE;
`else
          state_d = S_CREDIT;
`endif
        end
      end
`ifdef VENDING_CHANGE_EN
      S_CHANGE: begin
        err_d    = coin_valid;
        credit_d = credit_q - CREDIT_W'(1);
        if (credit_q == CREDIT_W'(1)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CHANGE;
        end
      end
`endif
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase
  end

  // A restock and a vend of the same item cancel out, even at saturation.
  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) begin
      if (restock && (restock_item == SW'(i)) && (state_q == S_VEND) && (sel_q == SW'(i))) begin
        stock_d[i] = stock_q[i];
      end else if ((state_q == S_VEND) && (sel_q == SW'(i))) begin
        stock_d[i] = stock_q[i] - STOCK_W'(1);
      end else if (restock && (restock_item == SW'(i)) && (stock_q[i] != STOCK_MAX)) begin
        stock_d[i] = stock_q[i] + STOCK_W'(1);
      end else begin
        stock_d[i] = stock_q[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) sold_out[i] = (stock_q[i] == '0);
  end

  assign item_out = (state_q == S_VEND);
  assign item_id  = (state_q == S_VEND) ? sel_q : '0;
`ifdef VENDING_CHANGE_EN
  assign change_out = (state_q == S_CHANGE);
  assign busy       = (state_q == S_VEND) || (state_q == S_CHANGE);
`else
  assign change_out = 1'b0;
  assign busy       = (state_q == S_VEND);
`endif
  assign credit = credit_q;
  assign err    = err_q;

endmodule
